// File: rtl/sqr_pkg.sv
// Shared widths, state encoding and helpers for the radix-4 shift-add squarer.
package sqr_pkg;

  localparam int OPW  = 16;
  localparam int RESW = 2 * OPW;
  localparam int ITER = OPW / 2;
  localparam int CNTW = $clog2(ITER);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } sqr_state_e;

  // 3*v needs two extra bits so the top partial product never wraps
  function automatic logic [OPW+1:0] triple(input logic [OPW-1:0] v);
    return {2'b00, v} + {1'b0, v, 1'b0};
  endfunction

endpackage

// File: rtl/square_u16_if.sv
// Operand and result handshakes of the squarer; master drives operands, slave is the squarer.
interface square_u16_if;
  import sqr_pkg::*;

  logic            vld_in;
  logic            rdy_in;
  logic [OPW-1:0]  x;
  logic            vld_out;
  logic            rdy_out;
  logic [RESW-1:0] y;

  modport master (
    output vld_in, x, rdy_out,
    input  rdy_in, vld_out, y
  );

  modport slave (
    input  vld_in, x, rdy_out,
    output rdy_in, vld_out, y
  );

endinterface

// File: rtl/sqr_r4_step.sv
// One radix-4 shift-add step: acc_nxt = 4*acc + d*x1, with 3*x1 precomputed as x3.
module sqr_r4_step
  import sqr_pkg::*;
(
  input  logic [RESW-1:0] acc,
  input  logic [1:0]      d,
  input  logic [OPW-1:0]  x1,
  input  logic [OPW+1:0]  x3,
  output logic [RESW-1:0] acc_nxt
);

  logic [RESW-1:0] pp;

  always_comb begin
    pp = '0;
    case (d)
      2'd1:    pp = {{(RESW-OPW){1'b0}}, x1};
      2'd2:    pp = {{(RESW-OPW-1){1'b0}}, x1, 1'b0};
      2'd3:    pp = {{(RESW-OPW-2){1'b0}}, x3};
      default: pp = '0;
    endcase
  end

  assign acc_nxt = {acc[RESW-3:0], 2'b00} + pp;

endmodule

// File: rtl/square_u16.sv
// Multi-cycle unsigned squarer: consumes the operand two bits per cycle, MSB first.
//   state | meaning
//   IDLE  | waiting for an operand, rdy_in high
//   BUSY  | ITER shift-add steps in flight, inputs stalled
//   DONE  | result held on y until downstream takes it
module square_u16
  import sqr_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  square_u16_if.slave   bus
);

  sqr_state_e      state_q, state_d;
  logic [OPW-1:0]  m_q;
  logic [OPW-1:0]  x1_q;
  logic [OPW+1:0]  x3_q;
  logic [RESW-1:0] acc_q;
  logic [RESW-1:0] acc_nxt;
  logic [RESW-1:0] y_q;
  logic [CNTW-1:0] cnt_q;
  logic            rdy_in_c;
  logic            vld_out_c;
  logic            accept;
  logic            last_step;

  assign accept    = bus.vld_in & rdy_in_c;
  assign last_step = (state_q == BUSY) && (cnt_q == CNTW'(ITER - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = BUSY;
      BUSY:    if (last_step) state_d = DONE;
      DONE: begin
        // same-edge hand-over: result leaves while the next operand enters
        if (bus.rdy_out) state_d = bus.vld_in ? BUSY : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rdy_in_c  = 1'b0;
    vld_out_c = 1'b0;
    case (state_q)
      IDLE:    rdy_in_c = 1'b1;
      DONE: begin
        rdy_in_c  = bus.rdy_out;
        vld_out_c = 1'b1;
      end
      default: begin
        rdy_in_c  = 1'b0;
        vld_out_c = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_q   <= '0;
      x1_q  <= '0;
      x3_q  <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      y_q   <= '0;
    end else if (accept) begin
      m_q   <= bus.x;
      x1_q  <= bus.x;
      x3_q  <= triple(bus.x);
      acc_q <= '0;
      cnt_q <= '0;
    end else if (state_q == BUSY) begin
      acc_q <= acc_nxt;
      m_q   <= {m_q[OPW-3:0], 2'b00};
      cnt_q <= cnt_q + CNTW'(1);
      if (last_step) y_q <= acc_nxt;
    end
  end

  sqr_r4_step u_step (
    .acc     (acc_q),
    .d       (m_q[OPW-1 -: 2]),
    .x1      (x1_q),
    .x3      (x3_q),
    .acc_nxt (acc_nxt)
  );

  assign bus.rdy_in  = rdy_in_c;
  assign bus.vld_out = vld_out_c;
  assign bus.y       = y_q;

endmodule

// File: tb/tb_square_u16.sv
// Directed and randomised checks of square_u16 against hand-computed squares and an x*x scoreboard.
module tb_square_u16;
  import sqr_pkg::*;

  localparam int N_RND = 2000;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  square_u16_if bus ();

  square_u16 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // accept at edge E, expect nothing before E+8, result at E+8, IDLE at E+9
  task automatic run_op(input logic [15:0] xv, input logic [31:0] exp, input string tag);
    int early;
    early = 0;
    chk({tag, "_rdy"}, 32'(bus.rdy_in), 32'd1);
    bus.vld_in  = 1'b1;
    bus.x       = xv;
    bus.rdy_out = 1'b1;
    tick();
    bus.vld_in = 1'b0;
    for (int i = 1; i < 8; i++) begin
      tick();
      if (bus.vld_out) early++;
    end
    chk({tag, "_early"}, 32'(early), 32'd0);
    tick();
    chk({tag, "_vld"}, 32'(bus.vld_out), 32'd1);
    chk({tag, "_y"}, bus.y, exp);
    tick();
    chk({tag, "_idle_vld"}, 32'(bus.vld_out), 32'd0);
    chk({tag, "_idle_rdy"}, 32'(bus.rdy_in), 32'd1);
  endtask

  initial begin
    int bad;
    logic [15:0] q[$];
    logic [15:0] px;
    logic [15:0] e;
    logic [31:0] e32;
    logic [31:0] yv;
    logic af, of;
    bit   pend;
    int   acc_n, res_n;

    rst         = 1'b1;
    bus.vld_in  = 1'b0;
    bus.x       = '0;
    bus.rdy_out = 1'b1;
    repeat (2) tick();
    chk("rst_vld", 32'(bus.vld_out), 32'd0);
    chk("rst_rdy", 32'(bus.rdy_in), 32'd1);
    chk("rst_y", bus.y, 32'd0);
    rst = 1'b0;
    tick();

    run_op(16'd0,     32'd0,          "x0");
    run_op(16'd65535, 32'hFFFE0001,   "xmax");
    run_op(16'd12345, 32'd152399025,  "x12345");
    run_op(16'd3,     32'd9,          "x3");

    // backpressure hold with an ignored vld_in pulse
    bus.rdy_out = 1'b0;
    bus.vld_in  = 1'b1;
    bus.x       = 16'd40000;
    tick();
    bus.vld_in = 1'b0;
    repeat (8) tick();
    chk("bp_vld", 32'(bus.vld_out), 32'd1);
    chk("bp_y", bus.y, 32'd1600000000);
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 5) begin
        bus.vld_in = 1'b1;
        bus.x      = 16'd9;
        #1;
        chk("bp_rdy_in", 32'(bus.rdy_in), 32'd0);
      end
      tick();
      bus.vld_in = 1'b0;
      if (bus.vld_out !== 1'b1 || bus.y !== 32'd1600000000) bad++;
    end
    chk("bp_hold", 32'(bad), 32'd0);
    bus.rdy_out = 1'b1;
    tick();
    chk("bp_release", 32'(bus.vld_out), 32'd0);
    bad = 0;
    repeat (10) begin
      tick();
      if (bus.vld_out) bad++;
    end
    chk("bp_no_ghost", 32'(bad), 32'd0);

    // back-to-back with vld_in held high
    bus.rdy_out = 1'b1;
    bus.vld_in  = 1'b1;
    bus.x       = 16'd100;
    tick();
    bus.x = 16'd200;
    repeat (7) tick();
    tick();
    chk("b2b_vld1", 32'(bus.vld_out), 32'd1);
    chk("b2b_y1", bus.y, 32'd10000);
    chk("b2b_rdy", 32'(bus.rdy_in), 32'd1);
    tick();
    bus.vld_in = 1'b0;
    chk("b2b_busy", 32'(bus.vld_out), 32'd0);
    repeat (7) tick();
    tick();
    chk("b2b_vld2", 32'(bus.vld_out), 32'd1);
    chk("b2b_y2", bus.y, 32'd40000);
    tick();
    chk("b2b_idle", 32'(bus.rdy_in), 32'd1);

    // reset while BUSY
    bus.vld_in = 1'b1;
    bus.x      = 16'd500;
    tick();
    bus.vld_in = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk("mid_rst_vld", 32'(bus.vld_out), 32'd0);
    chk("mid_rst_rdy", 32'(bus.rdy_in), 32'd1);
    chk("mid_rst_y", bus.y, 32'd0);
    rst = 1'b0;
    bad = 0;
    repeat (10) begin
      tick();
      if (bus.vld_out) bad++;
    end
    chk("mid_rst_none", 32'(bad), 32'd0);
    run_op(16'd7, 32'd49, "x7");

    // random sweep against an in-order x*x scoreboard
    pend  = 1'b0;
    acc_n = 0;
    res_n = 0;
    px    = '0;
    for (int cyc = 0; cyc < 40000 && (acc_n < N_RND || q.size() > 0); cyc++) begin
      if (!pend && acc_n < N_RND && $urandom_range(0, 2) != 0) begin
        pend = 1'b1;
        case ($urandom_range(0, 7))
          0:       px = 16'd0;
          1:       px = 16'hFFFF;
          default: px = 16'($urandom);
        endcase
      end
      bus.vld_in  = pend;
      bus.x       = pend ? px : 16'($urandom);
      bus.rdy_out = ($urandom_range(0, 3) != 0);
      #1;
      af = bus.vld_in & bus.rdy_in;
      of = bus.vld_out & bus.rdy_out;
      yv = bus.y;
      tick();
      if (of) begin
        if (q.size() == 0) begin
          chk("rnd_extra", 32'd1, 32'd0);
        end else begin
          e   = q.pop_front();
          e32 = {16'd0, e};
          chk("rnd_y", yv, e32 * e32);
          res_n++;
        end
      end
      if (af) begin
        q.push_back(px);
        acc_n++;
        pend = 1'b0;
      end
    end
    bus.vld_in = 1'b0;
    chk("rnd_count", 32'(res_n), 32'(N_RND));
    chk("rnd_queue", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
